mm2s_ar_burst_gen: RTL and testbench
====================================

// Module: mm2s_ar_burst_gen
// PURPOSE
//  MM2S read-address stage of the AXI DMA. Accepts one transfer command (start address + byte length).
//  Splits it into AXI4 INCR bursts, capped by MAX_BURST and by 4 KB boundaries, and drives the AR channel.
//  Counts outstanding bursts via R-channel last beats; reports completion and sticky error.
//  Sits downstream of the DMA register/command block and upstream of the AXI master port.
// PARAMETERS
//  ADDR_WIDTH       32  AXI address width (params_pkg::ADDR_WIDTH)
//  DATA_WIDTH       32  AXI data width, multiple of 8 (params_pkg::DATA_WIDTH)
//  LEN_WIDTH        26  command byte-length width
//  MAX_BURST        16  max beats per burst, 1..256
//  MAX_OUTSTANDING  4   max issued bursts not yet completed by an R last beat
// PORTS
//  aclk        in   1           single clock domain
//  aresetn     in   1           async assert, active-low
//  cmd_valid   in   1           command valid
//  cmd_ready   out  1           high only in IDLE
//  cmd_addr    in   ADDR_WIDTH  start byte address
//  cmd_len     in   LEN_WIDTH   byte count
//  ar_valid    out  1           AR valid
//  ar_ready    in   1           AR ready
//  ar_addr     out  ADDR_WIDTH  burst address, beat-aligned
//  ar_len      out  8           beats-1
//  ar_size     out  3           log2(DATA_WIDTH/8)
//  ar_burst    out  2           constant 2'b01 (INCR)
//  r_hs        in   1           r_valid & r_ready
//  r_last      in   1           R last, qualified by r_hs
//  r_resp      in   2           R response, qualified by r_hs
//  busy        out  1           state != IDLE
//  done        out  1           1-cycle completion pulse
//  done_err    out  1           valid with done: any SLVERR/DECERR, or rejected command
// BEHAVIOUR
//  Reset (aresetn=0, async): state=IDLE, ar_valid=0, ar_addr=0, ar_len=0, done=0, done_err=0, outstanding=0, err_sticky=0.
//    cmd_ready=1 after release. A reset mid-transfer drops ar_valid immediately; in-flight bursts are forgotten.
//  BPB=DATA_WIDTH/8. offset=cmd_addr%BPB. total_beats=ceil((offset+cmd_len)/BPB).
//  FSM IDLE->CALC->ISSUE->(CALC|WAIT_R)->IDLE:
//   IDLE:   cmd_ready=1; on cmd handshake latch aligned addr and total_beats, clear err_sticky, go CALC.
//           cmd_len==0 -> no AR; done=1, done_err=1 next cycle; stay IDLE.
//   CALC:   burst=min(remaining, MAX_BURST, (4096-addr[11:0])/BPB); registered.
//           Stall here while outstanding==MAX_OUTSTANDING. Otherwise go ISSUE.
//   ISSUE:  ar_valid=1; addr/len held stable until ar_ready.
//           On handshake: addr+=burst*BPB, remaining-=burst, outstanding++.
//           Then remaining==0 -> WAIT_R, else CALC.
//   WAIT_R: when outstanding==0 -> done=1, done_err=err_sticky, go IDLE.
//  Latency: cmd handshake cycle T -> ar_valid at T+2. One bubble cycle between bursts.
//    done asserts the cycle after the final r_hs&r_last.
//  outstanding: ++ on AR handshake, -- on r_hs&r_last; a simultaneous inc/dec is net 0.
//    r_last with outstanding==0 is ignored; the counter never underflows.
//  err_sticky set on any r_hs with r_resp[1]==1 while busy.
//  Address arithmetic wraps modulo 2^ADDR_WIDTH; a burst never crosses a 4 KB boundary.
// CONFIGURATION
//  MM2S_UNALIGNED_EN defined:
//    unaligned cmd_addr accepted. First ar_addr = cmd_addr aligned down to BPB; offset is counted in total_beats.
//  MM2S_UNALIGNED_EN undefined:
//    cmd_addr%BPB!=0 -> command consumed, no AR issued, done=1 with done_err=1 next cycle.
// STRUCTURE
//  Add to params_pkg: BYTES_PER_BEAT, AXI_SIZE_BPB, AXI_BURST_INCR=2'b01, AXI_4K=4096, ar_state_e enum.
//  One combinational sub-module, mm2s_burst_calc: remaining, addr[11:0] -> burst beats.
// TESTING (DATA_WIDTH=32, ar_ready=1 unless stated)
//  1 addr 0x1000, len 64 -> one AR: addr 0x1000, len 15, size 2, burst 1.
//    One r_last -> done=1, done_err=0.
//  2 addr 0x0FF8, len 16 -> AR 0x0FF8 len 1, then AR 0x1000 len 1 (4 KB split).
//  3 addr 0x2000, len 100 -> AR 0x2000 len 15, then 0x2040 len 8. done after the 2nd r_last.
//  4 addr 0x0, len 1024, no R beats -> exactly 4 AR handshakes, then ar_valid low.
//    One r_last -> 5th AR at 0x100.
//  5 Test 1 with r_resp=2'b10 on beat 3 -> done=1, done_err=1. cmd_len=0 -> done_err=1, no AR.
//  6 addr 0x1002, len 4: macro on -> AR 0x1000 len 1. Macro off -> done_err=1, no AR.
//    Also: drop aresetn during ISSUE with ar_ready=0 -> ar_valid=0 at once, cmd_ready=1 after release.

Source files
------------

// File: rtl/params_pkg.sv
// ----------------------------------------------------------------------------
// params_pkg
//   Shared AXI / DMA constants and types for the MM2S read-address path.
//   Provides default bus widths, the AXI encodings used on the AR channel,
//   the 4 KB boundary constant and the AR burst-generator state type.
// ----------------------------------------------------------------------------
package params_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int AXI_SIZE_BPB   = $clog2(BYTES_PER_BEAT);

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         AXI_4K         = 4096;

    typedef enum logic [1:0] {
        AR_IDLE   = 2'd0,
        AR_CALC   = 2'd1,
        AR_ISSUE  = 2'd2,
        AR_WAIT_R = 2'd3
    } ar_state_e;

    // AxSIZE encoding for a given data-bus width in bits.
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/mm2s_burst_calc.sv
// ----------------------------------------------------------------------------
// mm2s_burst_calc
//   Combinational burst sizer. Picks the beat count of the next AXI INCR burst
//   as the minimum of the beats still to issue, MAX_BURST and the beats left
//   before the next 4 KB boundary.
// Ports
//   remaining  in   BEATS_W  beats still to be requested (non-zero when used)
//   addr_lo    in   12       low 12 bits of the beat-aligned burst address
//   burst      out  9        beats in the next burst (1..256)
// ----------------------------------------------------------------------------
module mm2s_burst_calc
    import params_pkg::*;
#(
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter int MAX_BURST  = 16,
    parameter int BEATS_W    = 28
) (
    input  logic [BEATS_W-1:0] remaining,
    input  logic [11:0]        addr_lo,
    output logic [8:0]         burst
);

    localparam int SIZE = $clog2(DATA_WIDTH / 8);

    logic [12:0] to_4k;
    logic [12:0] cap;

    always_comb begin
        // addr_lo is beat-aligned, so the division is exact.
        to_4k = (13'(AXI_4K) - {1'b0, addr_lo}) >> SIZE;
        cap   = (to_4k < 13'(MAX_BURST)) ? to_4k : 13'(MAX_BURST);
        burst = (remaining < BEATS_W'(cap)) ? 9'(remaining) : 9'(cap);
    end

endmodule

// File: rtl/mm2s_ar_burst_gen.sv
// ----------------------------------------------------------------------------
// mm2s_ar_burst_gen
//   MM2S read-address stage of the AXI DMA. Takes one command (start address,
//   byte length), splits it into AXI4 INCR bursts capped by MAX_BURST and by
//   4 KB boundaries, drives the AR channel, tracks outstanding bursts through
//   R last beats and reports completion with a sticky error flag.
//
// Optional feature macro: MM2S_UNALIGNED_EN
//   defined   : unaligned cmd_addr is accepted; the first burst starts at the
//               address aligned down to the bus width, and the leading offset
//               bytes are counted in the beat total.
//   undefined : an unaligned cmd_addr is consumed without issuing any AR and
//               reported as done with done_err.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   cmd_valid/ready        command handshake (ready only in IDLE)
//   cmd_addr, cmd_len      start byte address, byte count
//   ar_valid/ready         AR handshake
//   ar_addr/len/size/burst AR payload (INCR, beat-aligned)
//   r_hs, r_last, r_resp   R-channel beat handshake, last flag, response
//   busy                   state != IDLE
//   done, done_err         one-cycle completion pulse and its error status
// ----------------------------------------------------------------------------
module mm2s_ar_burst_gen
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH      = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = params_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH       = 26,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]            ar_len,
    output logic [2:0]            ar_size,
    output logic [1:0]            ar_burst,
    input  logic                  r_hs,
    input  logic                  r_last,
    input  logic [1:0]            r_resp,
    output logic                  busy,
    output logic                  done,
    output logic                  done_err
);

    localparam int BPB     = DATA_WIDTH / 8;
    localparam int SIZE    = $clog2(BPB);
    // offset + len + BPB-1 always fits in two extra bits.
    localparam int BEATS_W = LEN_WIDTH + 2;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

    ar_state_e            state;
    logic [BEATS_W-1:0]   remaining;
    logic [8:0]           burst_r;
    logic [8:0]           calc_burst;
    logic [OUT_W-1:0]     outstanding;
    logic [OUT_W-1:0]     outstanding_nxt;
    logic                 err_sticky;

    logic [ADDR_WIDTH-1:0] bpb_mask;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic [BEATS_W-1:0]    byte_span;
    logic [BEATS_W-1:0]    total_beats;
    logic                  unaligned;
    logic                  cmd_reject;
    logic                  ar_hs;
    logic                  r_done;
    logic                  resp_err;
    logic                  unused_resp;

    assign bpb_mask     = ADDR_WIDTH'(BPB - 1);
    assign offset       = cmd_addr & bpb_mask;
    assign addr_aligned = cmd_addr & ~bpb_mask;
    assign unaligned    = |offset;
    assign byte_span    = BEATS_W'(offset) + BEATS_W'(cmd_len) + BEATS_W'(BPB - 1);
    assign total_beats  = byte_span >> SIZE;

`ifdef MM2S_UNALIGNED_EN
    assign cmd_reject = (cmd_len == '0);
`else
    assign cmd_reject = (cmd_len == '0) || unaligned;
`endif

    assign cmd_ready = (state == AR_IDLE);
    assign busy      = (state != AR_IDLE);
    assign ar_size   = axi_size(DATA_WIDTH);
    assign ar_burst  = AXI_BURST_INCR;

    assign ar_hs       = ar_valid & ar_ready;
    // A stray last beat with nothing in flight is dropped so the count never wraps.
    assign r_done      = r_hs & r_last & (outstanding != '0);
    assign resp_err    = r_hs & r_resp[1];
    assign unused_resp = r_resp[0];

    mm2s_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .BEATS_W    (BEATS_W)
    ) u_burst_calc (
        .remaining (remaining),
        .addr_lo   (ar_addr[11:0]),
        .burst     (calc_burst)
    );

    always_comb begin
        outstanding_nxt = outstanding;
        if (ar_hs && !r_done) begin
            outstanding_nxt = outstanding + OUT_W'(1);
        end else if (!ar_hs && r_done) begin
            outstanding_nxt = outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_nxt;
        end
    end

    // ar_addr doubles as the running burst address; it only moves while
    // ar_valid is low, so the AR payload stays stable during ISSUE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= AR_IDLE;
            ar_valid   <= 1'b0;
            ar_addr    <= '0;
            ar_len     <= '0;
            burst_r    <= '0;
            remaining  <= '0;
            err_sticky <= 1'b0;
            done       <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            done     <= 1'b0;
            done_err <= 1'b0;
            if ((state != AR_IDLE) && resp_err) begin
                err_sticky <= 1'b1;
            end

            case (state)
                AR_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_reject) begin
                            done     <= 1'b1;
                            done_err <= 1'b1;
                        end else begin
                            ar_addr    <= addr_aligned;
                            remaining  <= total_beats;
                            err_sticky <= 1'b0;
                            state      <= AR_CALC;
                        end
                    end
                end

                AR_CALC: begin
                    if (outstanding != OUT_W'(MAX_OUTSTANDING)) begin
                        burst_r  <= calc_burst;
                        ar_len   <= 8'(calc_burst - 9'd1);
                        ar_valid <= 1'b1;
                        state    <= AR_ISSUE;
                    end
                end

                AR_ISSUE: begin
                    if (ar_ready) begin
                        ar_valid  <= 1'b0;
                        ar_addr   <= ar_addr + (ADDR_WIDTH'(burst_r) << SIZE);
                        remaining <= remaining - BEATS_W'(burst_r);
                        state     <= (remaining == BEATS_W'(burst_r)) ? AR_WAIT_R : AR_CALC;
                    end
                end

                AR_WAIT_R: begin
                    // Look at the next count so done lands the cycle after the final last beat.
                    if (outstanding_nxt == '0) begin
                        done     <= 1'b1;
                        done_err <= err_sticky | resp_err;
                        state    <= AR_IDLE;
                    end
                end

                default: state <= AR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm2s_ar_burst_gen.sv
// ----------------------------------------------------------------------------
// tb_mm2s_ar_burst_gen
//   Directed scoreboard bench for mm2s_ar_burst_gen (DATA_WIDTH=32). Stimulus
//   pushes the hand-computed AR bursts and completion status into queues; a
//   negedge monitor pops and compares them as the DUT presents AR handshakes
//   and done pulses.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mm2s_ar_burst_gen;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [25:0] cmd_len;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_hs;
    logic        r_last;
    logic [1:0]  r_resp;
    logic        busy;
    logic        done;
    logic        done_err;

    ar_exp_t exp_ar_q[$];
    logic    exp_done_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int ar_cnt   = 0;
    int done_cnt = 0;

    always #5 aclk = ~aclk;

    mm2s_ar_burst_gen dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_burst  (ar_burst),
        .r_hs      (r_hs),
        .r_last    (r_last),
        .r_resp    (r_resp),
        .busy      (busy),
        .done      (done),
        .done_err  (done_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: inputs change #1 after posedge, so a negedge sample sees the
    // values the next posedge will act on.
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            if (ar_valid && ar_ready) begin
                ar_cnt++;
                if (exp_ar_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ar: got addr 0x%0h len %0d, none required", ar_addr, ar_len);
                end else begin
                    ar_exp_t e;
                    e = exp_ar_q.pop_front();
                    chk("ar_addr", 64'(ar_addr), 64'(e.addr));
                    chk("ar_len", 64'(ar_len), 64'(e.len));
                    chk("ar_size_burst", 64'({ar_size, ar_burst}), 64'({3'd2, 2'b01}));
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got done_err %0b, no done required", done_err);
                end else begin
                    chk("done_err", 64'(done_err), 64'(exp_done_q.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_exp_t e;
        e.addr = a;
        e.len  = l;
        exp_ar_q.push_back(e);
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [25:0] l);
        int guard;
        guard = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        while (!cmd_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'(1));
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic r_burst(input int beats, input int err_idx);
        for (int i = 0; i < beats; i++) begin
            r_hs   = 1'b1;
            r_last = (i == beats - 1);
            r_resp = (i == err_idx) ? 2'b10 : 2'b00;
            step();
        end
        r_hs   = 1'b0;
        r_last = 1'b0;
        r_resp = 2'b00;
    endtask

    task automatic wait_ar(input int target);
        for (int i = 0; i < 400 && ar_cnt < target; i++) step();
        chk("wait_ar_reached", 64'(ar_cnt >= target), 64'(1));
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && done_cnt < target; i++) step();
        chk("wait_done_reached", 64'(done_cnt >= target), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        ar_ready  = 1'b1;
        r_hs      = 1'b0;
        r_last    = 1'b0;
        r_resp    = 2'b00;
        repeat (3) step();
        chk("rst_ar_valid", 64'(ar_valid), 64'(0));
        chk("rst_ar_addr", 64'(ar_addr), 64'(0));
        chk("rst_done", 64'({done, done_err}), 64'(0));
        aresetn = 1'b1;
        step();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));

        // Test 1: single 16-beat burst, latency T+2.
        push_ar(32'h0000_1000, 8'd15);
        exp_done_q.push_back(1'b0);
        run_cmd(32'h0000_1000, 26'd64);
        chk("lat_t1_no_valid", 64'(ar_valid), 64'(0));
        step();
        chk("lat_t2_valid", 64'(ar_valid), 64'(1));
        wait_ar(1);
        r_burst(16, -1);
        wait_done(1);

        // Stray last beat while idle must not disturb the outstanding count.
        r_burst(1, -1);
        step();

        // Test 2: 4 KB split.
        push_ar(32'h0000_0FF8, 8'd1);
        push_ar(32'h0000_1000, 8'd1);
        exp_done_q.push_back(1'b0);
        run_cmd(32'h0000_0FF8, 26'd16);
        wait_ar(3);
        r_burst(2, -1);
        r_burst(2, -1);
        wait_done(2);

        // Test 3: 25 beats -> 16 + 9; done only after the second last beat.
        push_ar(32'h0000_2000, 8'd15);
        push_ar(32'h0000_2040, 8'd8);
        exp_done_q.push_back(1'b0);
        run_cmd(32'h0000_2000, 26'd100);
        wait_ar(5);
        r_burst(16, -1);
        repeat (3) step();
        chk("t3_no_early_done", 64'(done_cnt), 64'(2));
        r_burst(9, -1);
        wait_done(3);

        // Test 4: outstanding limit of 4, then release one at a time.
        base = ar_cnt;
        push_ar(32'h0000_0000, 8'd15);
        push_ar(32'h0000_0040, 8'd15);
        push_ar(32'h0000_0080, 8'd15);
        push_ar(32'h0000_00C0, 8'd15);
        run_cmd(32'h0000_0000, 26'd1024);
        wait_ar(base + 4);
        repeat (20) step();
        chk("t4_stalled_valid", 64'(ar_valid), 64'(0));
        chk("t4_stalled_count", 64'(ar_cnt), 64'(base + 4));
        push_ar(32'h0000_0100, 8'd15);
        r_burst(1, -1);
        wait_ar(base + 5);
        for (int i = 0; i < 11; i++) push_ar(32'h0000_0140 + 32'(i) * 32'h40, 8'd15);
        exp_done_q.push_back(1'b0);
        for (int k = 2; k <= 16; k++) begin
            wait_ar(base + k);
            r_burst(1, -1);
        end
        wait_done(4);
        chk("t4_total_ars", 64'(ar_cnt), 64'(base + 16));

        // Test 5a: SLVERR on beat 3 makes done_err sticky.
        push_ar(32'h0000_1000, 8'd15);
        exp_done_q.push_back(1'b1);
        run_cmd(32'h0000_1000, 26'd64);
        wait_ar(ar_cnt + 1);
        r_burst(16, 2);
        wait_done(5);

        // Test 5b: zero length -> error completion, no AR.
        base = ar_cnt;
        exp_done_q.push_back(1'b1);
        run_cmd(32'h0000_3000, 26'd0);
        wait_done(6);
        repeat (5) step();
        chk("t5b_no_ar", 64'(ar_cnt), 64'(base));

        // Test 6: unaligned start address.
        base = ar_cnt;
`ifdef MM2S_UNALIGNED_EN
        push_ar(32'h0000_1000, 8'd1);
        exp_done_q.push_back(1'b0);
        run_cmd(32'h0000_1002, 26'd4);
        wait_ar(base + 1);
        r_burst(2, -1);
        wait_done(7);
`else
        exp_done_q.push_back(1'b1);
        run_cmd(32'h0000_1002, 26'd4);
        wait_done(7);
        repeat (5) step();
        chk("t6_no_ar", 64'(ar_cnt), 64'(base));
`endif

        // Address wrap across 2^32 with a 4 KB cap on the first burst.
        push_ar(32'hFFFF_FFC0, 8'd15);
        push_ar(32'h0000_0000, 8'd15);
        exp_done_q.push_back(1'b0);
        run_cmd(32'hFFFF_FFC0, 26'd128);
        wait_ar(ar_cnt + 2);
        r_burst(16, -1);
        r_burst(16, -1);
        wait_done(8);

        // Reset during ISSUE with ar_ready low.
        base = ar_cnt;
        ar_ready = 1'b0;
        run_cmd(32'h0000_3000, 26'd64);
        step();
        chk("rst_mid_valid_before", 64'(ar_valid), 64'(1));
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_valid_drop", 64'(ar_valid), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        step();
        aresetn = 1'b1;
        step();
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
        ar_ready = 1'b1;
        repeat (10) step();
        chk("rst_mid_no_ar", 64'(ar_cnt), 64'(base));

        // Recovery after reset: counter was cleared, new command completes.
        push_ar(32'h0000_1000, 8'd0);
        exp_done_q.push_back(1'b0);
        run_cmd(32'h0000_1000, 26'd4);
        wait_ar(base + 1);
        r_burst(1, -1);
        wait_done(9);

        repeat (5) step();
        chk("ar_queue_drained", 64'(exp_ar_q.size()), 64'(0));
        chk("done_queue_drained", 64'(exp_done_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
